// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard link: deframer state encoding,
// protocol prefix bytes and a classifier for bytes that are passed through
// as raw bytes but never turned into key events.
// No ports; imported by ps2_line_filter and ps2_kbd_rx.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;

  // Bytes that are protocol/status traffic (pause prefix, BAT ok, ACK,
  // echo, resend): they reach byte_stb but abandon any pending prefix
  // instead of producing a key event.
  function automatic logic isPassOnly(input logic [7:0] b);
    return (b == PS2_PAUSE) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hEE) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Two-flop synchroniser plus level debounce for one PS/2 line, with a
// single-cycle pulse whenever the filtered level goes from 1 to 0.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   line_i   raw asynchronous line
//   fall_o   1-cycle pulse on an accepted 1->0 transition
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          fall_q;

  // The filtered level only flips after FILTER_LEN consecutive synchronised
  // samples disagree with it; any agreeing sample restarts the count, so a
  // pulse shorter than FILTER_LEN cycles is never seen downstream. The line
  // idles high, so the filter wakes up believing the line is high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          fall_q  <= ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// Device-to-host PS/2 keyboard receiver: deglitches the link, deframes
// 11-bit frames, checks odd parity and stop bit, and folds E0/F0 prefixes
// into one key event per make/break code.
// Ports:
//   clk_sys_i     system clock, the only clock
//   reset_i       synchronous active-high reset
//   ps2_clk_i     PS/2 clock (asynchronous)
//   ps2_data_i    PS/2 data (asynchronous)
//   byte_out_o    last good raw byte
//   byte_stb_o    pulse: byte_out_o updated
//   key_code_o    scancode of last key event
//   key_ext_o     last key event was E0-prefixed
//   key_rel_o     last key event was a break (F0-prefixed)
//   key_stb_o     pulse: key_* updated
//   parity_err_o  pulse: frame dropped for bad parity
//   frame_err_o   pulse: bad start/stop bit or mid-frame timeout
//   busy_o        a frame is in progress
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 66667
) (
  input  logic       clk_sys_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_out_o,
  output logic       byte_stb_o,
  output logic [7:0] key_code_o,
  output logic       key_ext_o,
  output logic       key_rel_o,
  output logic       key_stb_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic      clkFall;
  logic      dataBit;
  logic [1:0] dataSync_q;

  ps2State_e state_q,     state_d;
  logic [2:0] bitCnt_q,   bitCnt_d;
  logic [7:0] shift_q,    shift_d;
  logic       parity_q,   parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic       extPend_q,  extPend_d;
  logic       relPend_q,  relPend_d;
  logic [7:0] byteOut_q,  byteOut_d;
  logic       byteStb_q,  byteStb_d;
  logic [7:0] keyCode_q,  keyCode_d;
  logic       keyExt_q,   keyExt_d;
  logic       keyRel_q,   keyRel_d;
  logic       keyStb_q,   keyStb_d;
  logic       parityErr_q, parityErr_d;
  logic       frameErr_q, frameErr_d;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) uClkFilter (
    .clk_i  (clk_sys_i),
    .reset_i(reset_i),
    .line_i (ps2_clk_i),
    .fall_o (clkFall)
  );

  // Data only needs metastability protection: it is sampled well inside
  // its stable window, long after the debounced clock fall is recognised.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      dataSync_q <= 2'b11;
    end else begin
      dataSync_q <= {dataSync_q[0], ps2_data_i};
    end
  end

  assign dataBit = dataSync_q[1];

  // State register for the deframer, timeout, prefix folder and the
  // registered outputs; reset drops any partial frame silently.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
      extPend_q   <= 1'b0;
      relPend_q   <= 1'b0;
      byteOut_q   <= '0;
      byteStb_q   <= 1'b0;
      keyCode_q   <= '0;
      keyExt_q    <= 1'b0;
      keyRel_q    <= 1'b0;
      keyStb_q    <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
      extPend_q   <= extPend_d;
      relPend_q   <= relPend_d;
      byteOut_q   <= byteOut_d;
      byteStb_q   <= byteStb_d;
      keyCode_q   <= keyCode_d;
      keyExt_q    <= keyExt_d;
      keyRel_q    <= keyRel_d;
      keyStb_q    <= keyStb_d;
      parityErr_q <= parityErr_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // Next-state logic. The FSM only moves on a debounced clock fall, except
  // for the idle timeout which pulls a stalled frame back to IDLE. Every
  // frame ends in exactly one of byte/parity/frame strobes, and anything but
  // a good byte abandons a half-built prefix sequence.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    extPend_d   = extPend_q;
    relPend_d   = relPend_q;
    byteOut_d   = byteOut_q;
    byteStb_d   = 1'b0;
    keyCode_d   = keyCode_q;
    keyExt_d    = keyExt_q;
    keyRel_d    = keyRel_q;
    keyStb_d    = 1'b0;
    parityErr_d = 1'b0;
    frameErr_d  = 1'b0;

    if (state_q == IDLE || clkFall) begin
      timer_d = '0;
    end else if (timer_q != TW'(TIMEOUT_CYC)) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYC)) begin
      state_d    = IDLE;
      frameErr_d = 1'b1;
      extPend_d  = 1'b0;
      relPend_d  = 1'b0;
    end else if (clkFall) begin
      case (state_q)
        IDLE: begin
          if (!dataBit) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end else begin
            frameErr_d = 1'b1;
            extPend_d  = 1'b0;
            relPend_d  = 1'b0;
          end
        end
        DATA: begin
          shift_d  = {dataBit, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = dataBit;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dataBit) begin
            frameErr_d = 1'b1;
            extPend_d  = 1'b0;
            relPend_d  = 1'b0;
          end else if (!(^{shift_q, parity_q})) begin
            parityErr_d = 1'b1;
            extPend_d   = 1'b0;
            relPend_d   = 1'b0;
          end else begin
            byteOut_d = shift_q;
            byteStb_d = 1'b1;
            if (shift_q == PS2_PFX_EXT) begin
              extPend_d = 1'b1;
            end else if (shift_q == PS2_PFX_REL) begin
              relPend_d = 1'b1;
            end else if (isPassOnly(shift_q)) begin
              extPend_d = 1'b0;
              relPend_d = 1'b0;
            end else begin
              keyCode_d = shift_q;
              keyExt_d  = extPend_q;
              keyRel_d  = relPend_q;
              keyStb_d  = 1'b1;
              extPend_d = 1'b0;
              relPend_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign byte_out_o   = byteOut_q;
  assign byte_stb_o   = byteStb_q;
  assign key_code_o   = keyCode_q;
  assign key_ext_o    = keyExt_q;
  assign key_rel_o    = keyRel_q;
  assign key_stb_o    = keyStb_q;
  assign parity_err_o = parityErr_q;
  assign frame_err_o  = frameErr_q;
  assign busy_o       = (state_q != IDLE);

endmodule
